// File: rtl/aes_block_sequencer.sv
// aes_block_sequencer: runs one AES block through the T-box custom-instruction unit, fetching round keys from a synchronous key RAM
module aes_block_sequencer #(
  parameter int NR = 10,
  parameter int KAW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_decrypt,
  input  logic [KAW-1:0] in_key_base,
  input  logic [127:0]   in_block,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_block,
  output logic [KAW-1:0] key_addr,
  input  logic [31:0]    key_rdata,
  output logic           ci_clk_en,
  output logic           ci_start,
  output logic [7:0]     ci_n,
  output logic [31:0]    ci_dataa,
  output logic [31:0]    ci_datab,
  input  logic           ci_done,
  input  logic [31:0]    ci_result,
  output logic           busy
);
  localparam int RW = $clog2(NR + 2);
  typedef enum logic [2:0] {IDLE, FA, FB, FC, ISSUE, WAIT, READ, OUT} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] rnd_q, rnd_d, nxt_rnd;
  logic [1:0] sub_q, sub_d, nxt_sub;
  logic [0:3][31:0] din_q, din_d, out_q, out_d;
  logic dec_q, dec_d;
  logic [KAW-1:0] base_q, base_d, key_addr_q, key_addr_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0] ci_dataa_q, ci_dataa_d, ci_datab_q, ci_datab_d;
  logic [7:0] ci_n_q, ci_n_d;
  logic ci_start_q, ci_start_d, ci_clk_en_q, ci_clk_en_d, out_valid_q, out_valid_d;

  function automatic logic [7:0] op_of(input logic [RW-1:0] r, input logic [1:0] s, input logic d);
    return int'(r) == 0 ? 8'd1 :
           int'(r) == NR + 1 ? (s == 2'd0 ? 8'd2 : 8'd1) :
           s == 2'd0 ? (int'(r) == 1 ? 8'd3 : 8'd2) :
           int'(r) == NR ? (d ? 8'd7 : 8'd6) : (d ? 8'd5 : 8'd4);
  endfunction

  function automatic logic [KAW-1:0] off_of(input logic [RW-1:0] r, input logic [1:0] s);
    return KAW'(int'(r) == 0 ? int'(s) : 4 * int'(r) + 2 * int'(s));
  endfunction

  function automatic logic fetch_of(input logic [RW-1:0] r, input logic [1:0] s);
    return int'(r) == 0 ? ~s[0] : int'(r) <= NR;
  endfunction

  assign nxt_rnd = (rnd_q == '0 ? sub_q == 2'd3 : sub_q[0]) ? rnd_q + RW'(1) : rnd_q;
  assign nxt_sub = rnd_q == '0 ? sub_q + 2'd1 : sub_q ^ 2'd1;

  always_comb begin
    state_d = state_q;
    rnd_d = rnd_q;
    sub_d = sub_q;
    din_d = din_q;
    out_d = out_q;
    dec_d = dec_q;
    base_d = base_q;
    key_addr_d = key_addr_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    ci_n_d = ci_n_q;
    ci_dataa_d = ci_dataa_q;
    ci_datab_d = ci_datab_q;
    ci_start_d = 1'b0;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (in_valid) begin
        din_d = in_block;
        dec_d = in_decrypt;
        base_d = in_key_base;
        rnd_d = '0;
        sub_d = '0;
        key_addr_d = in_key_base;
        state_d = FA;
      end
      FA: begin
        key_addr_d = key_addr_q + KAW'(1);
        state_d = FB;
      end
      FB: begin
        op_a_d = key_rdata;
        state_d = FC;
      end
      FC: begin
        op_b_d = key_rdata;
        ci_n_d = op_of(rnd_q, sub_q, dec_q);
        ci_dataa_d = rnd_q == '0 ? din_q[sub_q] ^ op_a_q : op_a_q;
        ci_datab_d = rnd_q == '0 ? '0 : key_rdata;
        ci_start_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: state_d = int'(rnd_q) == NR + 1 ? READ : WAIT;
      WAIT: if (ci_done) begin
        rnd_d = nxt_rnd;
        sub_d = nxt_sub;
        if (fetch_of(nxt_rnd, nxt_sub)) begin
          key_addr_d = base_q + off_of(nxt_rnd, nxt_sub);
          state_d = FA;
        end else begin
          ci_n_d = op_of(nxt_rnd, nxt_sub, dec_q);
          ci_dataa_d = nxt_rnd == '0 ? din_q[nxt_sub] ^ op_b_q : '0;
          ci_datab_d = '0;
          ci_start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      READ: if (ci_done) begin
        out_d[sub_q] = ci_result;
        if (sub_q == 2'd3) begin
          out_valid_d = 1'b1;
          state_d = OUT;
        end else begin
          sub_d = sub_q + 2'd1;
          ci_n_d = 8'd1;
          ci_dataa_d = '0;
          ci_datab_d = '0;
          ci_start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ci_clk_en_d = state_d != IDLE && state_d != OUT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rnd_q <= '0;
      sub_q <= '0;
      din_q <= '0;
      out_q <= '0;
      dec_q <= 1'b0;
      base_q <= '0;
      key_addr_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      ci_n_q <= '0;
      ci_dataa_q <= '0;
      ci_datab_q <= '0;
      ci_start_q <= 1'b0;
      ci_clk_en_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q <= rnd_d;
      sub_q <= sub_d;
      din_q <= din_d;
      out_q <= out_d;
      dec_q <= dec_d;
      base_q <= base_d;
      key_addr_q <= key_addr_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      ci_n_q <= ci_n_d;
      ci_dataa_q <= ci_dataa_d;
      ci_datab_q <= ci_datab_d;
      ci_start_q <= ci_start_d;
      ci_clk_en_q <= ci_clk_en_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready = state_q == IDLE;
  assign busy = state_q != IDLE && state_q != OUT;
  assign out_valid = out_valid_q;
  assign out_block = out_q;
  assign key_addr = key_addr_q;
  assign ci_clk_en = ci_clk_en_q;
  assign ci_start = ci_start_q;
  assign ci_n = ci_n_q;
  assign ci_dataa = ci_dataa_q;
  assign ci_datab = ci_datab_q;
endmodule
